// File: rtl/huffman_decoder_stream.sv
// Streaming JPEG baseline Huffman decoder: multi-bit MSB-first input,
// registered canonical DC/AC luminance LUTs, (run, size, value) tuples out.

module huffman_canon_lut #(
    parameter int               NV   = 12,
    parameter logic [16*8-1:0]  BITS = '0,
    parameter logic [NV*8-1:0]  VALS = '0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] code_in,
    input  logic [5:0]  code_len_in,
    output logic        hit_out,
    output logic [4:0]  codesize_out,
    output logic [7:0]  symbol_out
);
    logic        hit_d, hit_q;
    logic [4:0]  len_d, len_q;
    logic [7:0]  sym_d, sym_q;
    logic [7:0]  idx;
    logic [7:0]  ofs;
    logic [17:0] first, t, n;

    // Canonical decode: codes of length l occupy [first, first+n) at that length.
    always_comb begin
        hit_d = 1'b0;
        len_d = '0;
        idx   = '0;
        ofs   = '0;
        first = '0;
        t     = '0;
        n     = '0;
        for (int l = 1; l <= 16; l++) begin
            n = {10'd0, BITS[(16-l)*8 +: 8]};
            t = {2'b00, code_in} >> (16 - l);
            if (!hit_d && (6'(l) <= code_len_in) && (t >= first) && ((t - first) < n)) begin
                hit_d = 1'b1;
                len_d = 5'(l);
                idx   = ofs + 8'(t - first);
            end
            first = (first + n) << 1;
            ofs   = ofs + n[7:0];
        end
        sym_d = VALS[(NV - 1 - int'(idx)) * 8 +: 8];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_q <= 1'b0;
            len_q <= '0;
            sym_q <= '0;
        end else begin
            hit_q <= hit_d;
            len_q <= len_d;
            sym_q <= sym_d;
        end
    end

    assign hit_out      = hit_q;
    assign codesize_out = len_q;
    assign symbol_out   = sym_q;
endmodule

module huffman_dc_lut (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] code_in,
    input  logic [5:0]  code_len_in,
    output logic        hit_out,
    output logic [4:0]  codesize_out,
    output logic [7:0]  symbol_out
);
    huffman_canon_lut #(
        .NV   (12),
        .BITS (128'h00_01_05_01_01_01_01_01_01_00_00_00_00_00_00_00),
        .VALS (96'h00_01_02_03_04_05_06_07_08_09_0a_0b)
    ) u_lut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .code_in      (code_in),
        .code_len_in  (code_len_in),
        .hit_out      (hit_out),
        .codesize_out (codesize_out),
        .symbol_out   (symbol_out)
    );
endmodule

module huffman_ac_lut (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] code_in,
    input  logic [5:0]  code_len_in,
    output logic        hit_out,
    output logic [4:0]  codesize_out,
    output logic [7:0]  symbol_out
);
    localparam logic [162*8-1:0] AC_VALS = {
        64'h01_02_03_00_04_11_05_12, 64'h21_31_41_06_13_51_61_07,
        64'h22_71_14_32_81_91_a1_08, 64'h23_42_b1_c1_15_52_d1_f0,
        64'h24_33_62_72_82_09_0a_16, 64'h17_18_19_1a_25_26_27_28,
        64'h29_2a_34_35_36_37_38_39, 64'h3a_43_44_45_46_47_48_49,
        64'h4a_53_54_55_56_57_58_59, 64'h5a_63_64_65_66_67_68_69,
        64'h6a_73_74_75_76_77_78_79, 64'h7a_83_84_85_86_87_88_89,
        64'h8a_92_93_94_95_96_97_98, 64'h99_9a_a2_a3_a4_a5_a6_a7,
        64'ha8_a9_aa_b2_b3_b4_b5_b6, 64'hb7_b8_b9_ba_c2_c3_c4_c5,
        64'hc6_c7_c8_c9_ca_d2_d3_d4, 64'hd5_d6_d7_d8_d9_da_e1_e2,
        64'he3_e4_e5_e6_e7_e8_e9_ea, 64'hf1_f2_f3_f4_f5_f6_f7_f8,
        16'hf9_fa
    };

    huffman_canon_lut #(
        .NV   (162),
        .BITS (128'h00_02_01_03_03_02_04_03_05_05_04_04_00_00_01_7d),
        .VALS (AC_VALS)
    ) u_lut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .code_in      (code_in),
        .code_len_in  (code_len_in),
        .hit_out      (hit_out),
        .codesize_out (codesize_out),
        .symbol_out   (symbol_out)
    );
endmodule

module huffman_decoder_stream #(
    parameter int  IN_W        = 8,
    parameter int  BUF_W       = 32,
    parameter int  BLOCK_LEN   = 64,
    parameter int  VALUE_W     = 11,
    parameter bit  SIGN_EXTEND = 1'b1,
    localparam int NB_W        = $clog2(IN_W + 1)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [IN_W-1:0]    data_in,
    input  logic [NB_W-1:0]    nbits_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic               flush_in,
    output logic [VALUE_W-1:0] value_out,
    output logic [5:0]         run_out,
    output logic [4:0]         size_out,
    output logic               dc_out,
    output logic               eob_out,
    output logic               last_out,
    output logic               error_out,
    output logic               valid_out,
    input  logic               ready_in
);
    localparam int LEN_W = $clog2(BUF_W + 1);
    localparam int CNT_W = $clog2(BLOCK_LEN + 17);

    typedef enum logic [1:0] {
        S_DC_CODE,
        S_DC_VAL,
        S_AC_CODE,
        S_AC_VAL
    } state_t;

    state_t             st_q, st_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         run_q, run_d;
    logic [4:0]         size_q, size_d;
    logic               stale_q, stale_d;
    logic               err_q, err_d;
    logic               vld_q, vld_d;
    logic [VALUE_W-1:0] val_q, val_d;
    logic [5:0]         orun_q, orun_d;
    logic [4:0]         osize_q, osize_d;
    logic               dc_q, dc_d;
    logic               eob_q, eob_d;
    logic               last_q, last_d;

    logic [15:0]        code;
    logic [5:0]         code_len;
    logic               dc_hit, ac_hit;
    logic [4:0]         dc_csz, ac_csz;
    logic [7:0]         dc_sym, ac_sym;
    logic [4:0]         cons;
    logic               acc, advance, blk_end;
    logic [LEN_W-1:0]   shamt;
    logic [15:0]        mask, vbits;
    logic signed [16:0] sval;
    logic [VALUE_W-1:0] val_dec;
    logic [3:0]         ac_run;
    logic [CNT_W-1:0]   nxt;

    assign ready_out = rst_n_in && (len_q <= LEN_W'(BUF_W - IN_W));
    assign acc       = valid_in && ready_out && !flush_in;
    assign advance   = !vld_q || ready_in;

    // Top 16 valid bits, zero-padded below when fewer are buffered.
    assign code     = 16'({buf_q, 16'd0} >> len_q);
    assign code_len = (len_q >= LEN_W'(16)) ? 6'd16 : 6'(len_q);

    huffman_dc_lut u_dc_lut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .code_in      (code),
        .code_len_in  (code_len),
        .hit_out      (dc_hit),
        .codesize_out (dc_csz),
        .symbol_out   (dc_sym)
    );

    huffman_ac_lut u_ac_lut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .code_in      (code),
        .code_len_in  (code_len),
        .hit_out      (ac_hit),
        .codesize_out (ac_csz),
        .symbol_out   (ac_sym)
    );

    assign shamt = (len_q >= LEN_W'(size_q)) ? len_q - LEN_W'(size_q) : '0;
    assign mask  = 16'((17'd1 << size_q) - 17'd1);
    assign vbits = 16'(buf_q >> shamt) & mask;

    always_comb begin
        sval = '0;
        if (size_q != 5'd0) begin
            if (vbits[4'(size_q - 5'd1)])
                sval = {1'b0, vbits};
            else
                sval = $signed({1'b0, vbits}) - $signed({1'b0, mask});
        end
    end

    assign val_dec = SIGN_EXTEND ? VALUE_W'(sval) : VALUE_W'(vbits);
    assign ac_run  = (st_q == S_AC_VAL) ? run_q : ac_sym[7:4];
    assign nxt     = cnt_q + CNT_W'(ac_run) + CNT_W'(1);

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        size_d  = size_q;
        err_d   = err_q;
        vld_d   = vld_q;
        val_d   = val_q;
        orun_d  = orun_q;
        osize_d = osize_q;
        dc_d    = dc_q;
        eob_d   = eob_q;
        last_d  = last_q;
        cons    = '0;
        blk_end = 1'b0;
        if (advance) begin
            vld_d = 1'b0;
            unique case (st_q)
                S_DC_CODE: begin
                    if (!stale_q && dc_hit) begin
                        cons   = dc_csz;
                        cnt_d  = CNT_W'(1);
                        size_d = dc_sym[4:0];
                        if (dc_sym == 8'd0) begin
                            vld_d   = 1'b1;
                            val_d   = '0;
                            orun_d  = '0;
                            osize_d = '0;
                            dc_d    = 1'b1;
                            eob_d   = 1'b0;
                            last_d  = 1'b0;
                            st_d    = S_AC_CODE;
                        end else begin
                            st_d = S_DC_VAL;
                        end
                    end
                end
                S_DC_VAL: begin
                    if (len_q >= LEN_W'(size_q)) begin
                        cons    = size_q;
                        vld_d   = 1'b1;
                        val_d   = val_dec;
                        orun_d  = '0;
                        osize_d = size_q;
                        dc_d    = 1'b1;
                        eob_d   = 1'b0;
                        last_d  = 1'b0;
                        st_d    = S_AC_CODE;
                    end
                end
                S_AC_CODE: begin
                    if (!stale_q && ac_hit) begin
                        cons = ac_csz;
                        if (ac_sym == 8'h00) begin
                            vld_d   = 1'b1;
                            val_d   = '0;
                            orun_d  = 6'(CNT_W'(BLOCK_LEN) - cnt_q);
                            osize_d = '0;
                            dc_d    = 1'b0;
                            eob_d   = 1'b1;
                            last_d  = 1'b1;
                            st_d    = S_DC_CODE;
                        end else if (ac_sym[3:0] == 4'd0) begin
                            vld_d   = 1'b1;
                            val_d   = '0;
                            orun_d  = {2'b00, ac_sym[7:4]};
                            osize_d = '0;
                            dc_d    = 1'b0;
                            eob_d   = 1'b0;
                            blk_end = 1'b1;
                        end else begin
                            run_d  = ac_sym[7:4];
                            size_d = {1'b0, ac_sym[3:0]};
                            st_d   = S_AC_VAL;
                        end
                    end
                end
                S_AC_VAL: begin
                    if (len_q >= LEN_W'(size_q)) begin
                        cons    = size_q;
                        vld_d   = 1'b1;
                        val_d   = val_dec;
                        orun_d  = {2'b00, run_q};
                        osize_d = size_q;
                        dc_d    = 1'b0;
                        eob_d   = 1'b0;
                        blk_end = 1'b1;
                    end
                end
            endcase
            if (blk_end) begin
                cnt_d  = nxt;
                last_d = (nxt >= CNT_W'(BLOCK_LEN));
                st_d   = (nxt >= CNT_W'(BLOCK_LEN)) ? S_DC_CODE : S_AC_CODE;
                if (nxt > CNT_W'(BLOCK_LEN))
                    err_d = 1'b1;
            end
        end
        if (flush_in) begin
            st_d  = S_DC_CODE;
            cnt_d = '0;
            vld_d = 1'b0;
            err_d = 1'b0;
            cons  = '0;
        end
    end

    // Any consume invalidates the LUT result registered from the old window.
    always_comb begin
        stale_d = flush_in || (cons != 5'd0);
        buf_d   = buf_q;
        len_d   = len_q - LEN_W'(cons);
        if (acc) begin
            buf_d = (buf_q << nbits_in) | BUF_W'(data_in >> (IN_W - int'(nbits_in)));
            len_d = len_d + LEN_W'(nbits_in);
        end
        if (flush_in)
            len_d = '0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            st_q    <= S_DC_CODE;
            buf_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            size_q  <= '0;
            stale_q <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            val_q   <= '0;
            orun_q  <= '0;
            osize_q <= '0;
            dc_q    <= 1'b0;
            eob_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            size_q  <= size_d;
            stale_q <= stale_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            val_q   <= val_d;
            orun_q  <= orun_d;
            osize_q <= osize_d;
            dc_q    <= dc_d;
            eob_q   <= eob_d;
            last_q  <= last_d;
        end
    end

    assign value_out = val_q;
    assign run_out   = orun_q;
    assign size_out  = osize_q;
    assign dc_out    = dc_q;
    assign eob_out   = eob_q;
    assign last_out  = last_q;
    assign error_out = err_q;
    assign valid_out = vld_q;
endmodule

// File: tb/tb_huffman_decoder_stream.sv
// Scoreboard bench for huffman_decoder_stream: signed and raw-magnitude
// instances share one input stream; tuples are checked on handshake.

module tb_huffman_decoder_stream;
    localparam int IN_W = 8;
    localparam int NB_W = $clog2(IN_W + 1);

    logic            clk_in = 1'b0;
    logic            rst_n_in = 1'b0;
    logic [IN_W-1:0] data_in = '0;
    logic [NB_W-1:0] nbits_in = '0;
    logic            valid_in = 1'b0;
    logic            flush_in = 1'b0;
    logic            ready_in = 1'b1;
    logic            ready_out, valid_out;
    logic [10:0]     value_out;
    logic [5:0]      run_out;
    logic [4:0]      size_out;
    logic            dc_out, eob_out, last_out, error_out;
    logic            raw_ready, raw_valid;
    logic [10:0]     raw_value;
    logic [5:0]      raw_run;
    logic [4:0]      raw_size;
    logic            raw_dc, raw_eob, raw_last, raw_error;

    always #5 clk_in = ~clk_in;

    huffman_decoder_stream u_dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .data_in   (data_in),
        .nbits_in  (nbits_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .flush_in  (flush_in),
        .value_out (value_out),
        .run_out   (run_out),
        .size_out  (size_out),
        .dc_out    (dc_out),
        .eob_out   (eob_out),
        .last_out  (last_out),
        .error_out (error_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    huffman_decoder_stream #(.SIGN_EXTEND(1'b0)) u_raw (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .data_in   (data_in),
        .nbits_in  (nbits_in),
        .valid_in  (valid_in),
        .ready_out (raw_ready),
        .flush_in  (flush_in),
        .value_out (raw_value),
        .run_out   (raw_run),
        .size_out  (raw_size),
        .dc_out    (raw_dc),
        .eob_out   (raw_eob),
        .last_out  (raw_last),
        .error_out (raw_error),
        .valid_out (raw_valid),
        .ready_in  (ready_in)
    );

    typedef struct {
        logic [10:0] val;
        logic [10:0] raw;
        logic [5:0]  run;
        logic [4:0]  size;
        logic        dc;
        logic        eob;
        logic        last;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    bit   bits_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   npop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic dc, input logic eob, input logic last,
                            input logic err, input int run, input int size,
                            input logic [10:0] val, input logic [10:0] raw);
        exp_t e;
        e.dc = dc; e.eob = eob; e.last = last; e.err = err;
        e.run = 6'(run); e.size = 5'(size); e.val = val; e.raw = raw;
        exp_q.push_back(e);
    endtask

    task automatic push_bits(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) == "1") bits_q.push_back(1'b1);
            else if (s.getc(i) == "0") bits_q.push_back(1'b0);
        end
    endtask

    task automatic drive(input int w);
        while (bits_q.size() > 0) begin
            int n;
            logic [IN_W-1:0] d;
            logic acc;
            n = (bits_q.size() < w) ? bits_q.size() : w;
            d = IN_W'($urandom);
            for (int i = 0; i < n; i++) d[IN_W-1-i] = bits_q[i];
            data_in = d;
            nbits_in = NB_W'(n);
            valid_in = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 500 && !acc; k++) begin
                @(negedge clk_in);
                acc = ready_out;
                @(posedge clk_in);
            end
            #1;
            if (!acc) begin
                check("beat accept timeout", 32'd0, 32'd1);
                bits_q.delete();
            end else begin
                repeat (n) void'(bits_q.pop_front());
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk_in);
            k++;
        end
        repeat (4) @(posedge clk_in);
        #1;
        check({tag, " drain"}, exp_q.size(), 0);
    endtask

    always @(negedge clk_in) begin
        if (rst_n_in && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected tuple", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                npop++;
                check("dc", dc_out, mon_e.dc);
                check("eob", eob_out, mon_e.eob);
                check("last", last_out, mon_e.last);
                check("err", error_out, mon_e.err);
                check("run", run_out, mon_e.run);
                check("size", size_out, mon_e.size);
                check("value", value_out, mon_e.val);
                check("raw value", raw_value, mon_e.raw);
            end
        end
    end

    task automatic full_block(input logic err);
        push_bits("00");
        push_exp(1, 0, 0, err, 0, 0, 0, 0);
        for (int i = 0; i < 63; i++) begin
            push_bits("001");
            push_exp(0, 0, i == 62, err, 0, 1, 11'd1, 11'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_low;
        int start;

        repeat (3) @(posedge clk_in);
        #1;
        check("ready during reset", ready_out, 0);
        rst_n_in = 1'b1;
        #1;
        check("reset ready", ready_out, 1);
        check("reset valid", valid_out, 0);
        check("reset error", error_out, 0);
        check("reset value", value_out, 0);
        check("reset last", last_out, 0);

        // DC size 3 magnitude 5, then EOB, bit-serial
        push_exp(1, 0, 0, 0, 0, 3, 11'd5, 11'd5);
        push_exp(0, 1, 1, 0, 63, 0, 0, 0);
        push_bits("100 101 1010");
        drive(1);
        drain("t1");

        // negative DC: bits 010 at size 3 -> -5 signed, 2 raw
        push_exp(1, 0, 0, 0, 0, 3, 11'h7FB, 11'd2);
        push_exp(0, 1, 1, 0, 63, 0, 0, 0);
        push_bits("100 010 1010");
        drive(3);
        drain("t2");

        // full 64-coefficient block without EOB, then a fresh DC
        full_block(1'b0);
        drive(8);
        push_bits("00 1010");
        push_exp(1, 0, 0, 0, 0, 0, 0, 0);
        push_exp(0, 1, 1, 0, 63, 0, 0, 0);
        drive(8);
        drain("t3");

        // downstream stall mid-block
        full_block(1'b0);
        saw_low = 1'b0;
        start = npop;
        fork
            drive(8);
            begin
                for (int k = 0; k < 2000 && npop < start + 5; k++) @(posedge clk_in);
                #1;
                ready_in = 1'b0;
                repeat (20) begin
                    @(negedge clk_in);
                    if (!ready_out) saw_low = 1'b1;
                end
                @(posedge clk_in);
                #1;
                ready_in = 1'b1;
            end
        join
        drain("t4");
        check("ready_out dropped on stall", saw_low, 1);

        // ZRL overrun: fourth ZRL pushes count to 65
        push_bits("00 11111111001 11111111001 11111111001 11111111001");
        push_exp(1, 0, 0, 0, 0, 0, 0, 0);
        push_exp(0, 0, 0, 0, 15, 0, 0, 0);
        push_exp(0, 0, 0, 0, 15, 0, 0, 0);
        push_exp(0, 0, 0, 0, 15, 0, 0, 0);
        push_exp(0, 0, 1, 1, 15, 0, 0, 0);
        push_bits("00 1010");
        push_exp(1, 0, 0, 1, 0, 0, 0, 0);
        push_exp(0, 1, 1, 1, 63, 0, 0, 0);
        drive(8);
        drain("t5");
        check("error sticky", error_out, 1);
        @(posedge clk_in);
        #1;
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        check("error cleared by flush", error_out, 0);

        // reset while waiting for AC value bits, with error set and bits buffered
        push_bits("00 11111111001 11111111001 11111111001 11111111001");
        push_exp(1, 0, 0, 0, 0, 0, 0, 0);
        push_exp(0, 0, 0, 0, 15, 0, 0, 0);
        push_exp(0, 0, 0, 0, 15, 0, 0, 0);
        push_exp(0, 0, 0, 0, 15, 0, 0, 0);
        push_exp(0, 0, 1, 1, 15, 0, 0, 0);
        push_bits("00 1011 01");
        push_exp(1, 0, 0, 1, 0, 0, 0, 0);
        drive(8);
        drain("t6 pre");
        check("error before reset", error_out, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async reset valid", valid_out, 0);
        check("async reset error", error_out, 0);
        check("async reset dc", dc_out, 0);
        check("async reset ready", ready_out, 0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        push_exp(1, 0, 0, 0, 0, 3, 11'd5, 11'd5);
        push_exp(0, 1, 1, 0, 63, 0, 0, 0);
        push_bits("100 101 1010");
        drive(1);
        drain("t6 post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
